disparity_wta_lr: RTL and testbench

Winner-take-all disparity selector that generates the left and right disparity streams consumed by the post-processing window (LR check plus hole filling). It accepts the aggregated cost volume one cost per cycle in left-image raster order. It emits the left disparity of each left pixel and the right disparity of each right pixel; the right disparities come from the same cost volume through a diagonal running-minimum buffer. Both outputs use the `valid_final_L/disp_L` and `valid_final_R/disp_R` stream convention of the post-processing input.

---
 rtl/disparity_wta_lr.sv | 181 ++++++++++++++++++
 tb/tb_disparity_wta_lr.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/disparity_wta_lr.sv
// rtl/disparity_wta_lr.sv - winner-take-all left/right disparity selector over a streamed cost volume
module disparity_wta_lr #(
   parameter int DWIDTH = 16,
   parameter int CWIDTH = 16,
   parameter int AWIDTH = 11,
   parameter int MAXD   = 256,
   parameter int FRAC   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clken,
   input  logic [AWIDTH-1:0] width,
   input  logic [8:0]        range,
   input  logic [CWIDTH-1:0] cost_in,
   input  logic              cost_valid,
   output logic              cost_ready,
   output logic              valid_final_L,
   output logic [DWIDTH-1:0] disp_L,
   output logic              valid_final_R,
   output logic [DWIDTH-1:0] disp_R
);
   localparam int IW = (MAXD > 1) ? $clog2(MAXD) : 1;

   typedef enum logic {S_RUN, S_FLUSH} state_t;

   state_t            state_q, state_d;
   logic [AWIDTH-1:0] x_cnt_q, x_cnt_d;
   logic [AWIDTH-1:0] width_q, width_d;
   logic [8:0]        d_cnt_q, d_cnt_d;
   logic [8:0]        range_q, range_d;
   logic [CWIDTH-1:0] min_cost_q, min_cost_d;
   logic [8:0]        min_d_q, min_d_d;
   logic [8:0]        fcnt_q, fcnt_d;
   logic [IW-1:0]     fidx_q, fidx_d;
   logic              vl_q, vl_d, vr_q, vr_d;
   logic [DWIDTH-1:0] dl_q, dl_d, dr_q, dr_d;

   // Right buffer: best {cost, d} seen so far for each right pixel, indexed (x-d) mod MAXD
   logic [CWIDTH-1:0] buf_cost [MAXD];
   logic [8:0]        buf_d    [MAXD];

   logic              accept, row_start, last_d, last_x, in_tri, l_take, r_take;
   logic [AWIDTH-1:0] eff_width;
   logic [8:0]        eff_range;
   logic [IW-1:0]     idx;
   logic [CWIDTH-1:0] merged_cost;
   logic [8:0]        merged_d;

   function automatic logic [DWIDTH-1:0] to_disp(input logic [8:0] d);
      to_disp = DWIDTH'(d) << FRAC;
   endfunction

   assign cost_ready    = (state_q == S_RUN);
   assign accept        = cost_valid & cost_ready & clken;
   assign row_start     = (x_cnt_q == '0) && (d_cnt_q == '0);
   // Geometry is taken live on the first cost of a row, then from the latched copy
   assign eff_width     = row_start ? width : width_q;
   assign eff_range     = row_start ? range : range_q;
   assign last_d        = (d_cnt_q == eff_range - 9'd1);
   assign last_x        = (x_cnt_q == eff_width - AWIDTH'(1));
   // Only costs with d <= x refer to a real right pixel (x-d >= 0)
   assign in_tri        = (AWIDTH'(d_cnt_q) <= x_cnt_q);
   assign idx           = x_cnt_q[IW-1:0] - d_cnt_q[IW-1:0];
   assign l_take        = (d_cnt_q == 9'd0) || (in_tri && (cost_in < min_cost_q));
   assign r_take        = (d_cnt_q == 9'd0) || (cost_in < buf_cost[idx]);
   assign merged_cost   = r_take ? cost_in : buf_cost[idx];
   assign merged_d      = r_take ? d_cnt_q : buf_d[idx];

   assign valid_final_L = vl_q & clken;
   assign valid_final_R = vr_q & clken;
   assign disp_L        = dl_q;
   assign disp_R        = dr_q;

   // Next-state: row counters, left running minimum, flush sequencing and output pulses
   always_comb begin
      state_d    = state_q;
      x_cnt_d    = x_cnt_q;
      d_cnt_d    = d_cnt_q;
      width_d    = width_q;
      range_d    = range_q;
      min_cost_d = min_cost_q;
      min_d_d    = min_d_q;
      fcnt_d     = fcnt_q;
      fidx_d     = fidx_q;
      vl_d       = vl_q;
      vr_d       = vr_q;
      dl_d       = dl_q;
      dr_d       = dr_q;
      if (clken) begin
         vl_d = 1'b0;
         vr_d = 1'b0;
         case (state_q)
            S_RUN: begin
               if (accept) begin
                  if (row_start) begin
                     width_d = width;
                     range_d = range;
                  end
                  if (l_take) begin
                     min_cost_d = cost_in;
                     min_d_d    = d_cnt_q;
                  end
                  if (last_d) begin
                     vl_d    = 1'b1;
                     dl_d    = to_disp(l_take ? d_cnt_q : min_d_q);
                     d_cnt_d = 9'd0;
                     if (in_tri) begin
                        vr_d = 1'b1;
                        dr_d = to_disp(merged_d);
                     end
                     if (last_x) begin
                        x_cnt_d = '0;
                        if (eff_range > 9'd1) begin
                           state_d = S_FLUSH;
                           fcnt_d  = eff_range - 9'd1;
                           fidx_d  = idx + IW'(1);
                        end
                     end else begin
                        x_cnt_d = x_cnt_q + AWIDTH'(1);
                     end
                  end else begin
                     d_cnt_d = d_cnt_q + 9'd1;
                  end
               end
            end
            S_FLUSH: begin
               vr_d   = 1'b1;
               dr_d   = to_disp(buf_d[fidx_q]);
               fidx_d = fidx_q + IW'(1);
               fcnt_d = fcnt_q - 9'd1;
               if (fcnt_q == 9'd1) begin
                  state_d = S_RUN;
               end
            end
            default: state_d = S_RUN;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_RUN;
         x_cnt_q    <= '0;
         d_cnt_q    <= '0;
         width_q    <= '0;
         range_q    <= '0;
         min_cost_q <= '0;
         min_d_q    <= '0;
         fcnt_q     <= '0;
         fidx_q     <= '0;
         vl_q       <= 1'b0;
         vr_q       <= 1'b0;
         dl_q       <= '0;
         dr_q       <= '0;
      end else begin
         state_q    <= state_d;
         x_cnt_q    <= x_cnt_d;
         d_cnt_q    <= d_cnt_d;
         width_q    <= width_d;
         range_q    <= range_d;
         min_cost_q <= min_cost_d;
         min_d_q    <= min_d_d;
         fcnt_q     <= fcnt_d;
         fidx_q     <= fidx_d;
         vl_q       <= vl_d;
         vr_q       <= vr_d;
         dl_q       <= dl_d;
         dr_q       <= dr_d;
      end
   end

   // Right buffer update; d=0 always initialises the entry so no reset is needed
   always_ff @(posedge clk) begin
      if (accept && in_tri) begin
         buf_cost[idx] <= merged_cost;
         buf_d[idx]    <= merged_d;
      end
   end

endmodule

// File: tb/tb_disparity_wta_lr.sv
// tb/tb_disparity_wta_lr.sv - randomized self-checking bench for disparity_wta_lr
module tb_disparity_wta_lr;
   localparam int DWIDTH = 16;
   localparam int CWIDTH = 16;
   localparam int AWIDTH = 11;
   localparam int MAXD   = 32;
   localparam int FRAC   = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              clken = 1'b1;
   logic [AWIDTH-1:0] width = '0;
   logic [8:0]        range = '0;
   logic [CWIDTH-1:0] cost_in = '0;
   logic              cost_valid = 1'b0;
   logic              cost_ready;
   logic              valid_final_L;
   logic [DWIDTH-1:0] disp_L;
   logic              valid_final_R;
   logic [DWIDTH-1:0] disp_R;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_l[$];
   logic [15:0] exp_r[$];
   int          costs[$];
   bit          ignore_out = 1'b0;
   bit          chk_coincide = 1'b0;
   int          flush_cycles = 0;

   disparity_wta_lr #(
      .DWIDTH(DWIDTH), .CWIDTH(CWIDTH), .AWIDTH(AWIDTH), .MAXD(MAXD), .FRAC(FRAC)
   ) dut (
      .clk(clk), .rst(rst), .clken(clken), .width(width), .range(range),
      .cost_in(cost_in), .cost_valid(cost_valid), .cost_ready(cost_ready),
      .valid_final_L(valid_final_L), .disp_L(disp_L),
      .valid_final_R(valid_final_R), .disp_R(disp_R)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Output monitor, sampled mid-cycle away from the active edge
   always @(negedge clk) begin
      if (rst) begin
         if (!cost_ready && clken) flush_cycles++;
         if (!clken) check("clken_gate", {30'd0, valid_final_L, valid_final_R}, 32'd0);
         if (chk_coincide) check("lr_coincide", {31'd0, valid_final_L}, {31'd0, valid_final_R});
         if (!ignore_out) begin
            if (valid_final_L) begin
               if (exp_l.size() == 0) check("L_extra", 32'd1, 32'd0);
               else check("disp_L", {16'd0, disp_L}, {16'd0, exp_l.pop_front()});
            end
            if (valid_final_R) begin
               if (exp_r.size() == 0) check("R_extra", 32'd1, 32'd0);
               else check("disp_R", {16'd0, disp_R}, {16'd0, exp_r.pop_front()});
            end
         end
      end
   end

   // Reference: WTA straight from the cost-volume definition C(x,d), costs[x*r+d]
   task automatic model_row(input int w, input int r);
      int best, bc, x;
      for (int xl = 0; xl < w; xl++) begin
         best = 0;
         bc   = costs[xl*r];
         for (int d = 1; d < r; d++)
            if (d <= xl && costs[xl*r+d] < bc) begin
               bc   = costs[xl*r+d];
               best = d;
            end
         exp_l.push_back(16'(best << FRAC));
      end
      for (int xr = 0; xr < w; xr++) begin
         best = 0;
         bc   = costs[xr*r];
         for (int d = 1; d < r; d++) begin
            x = xr + d;
            if (x < w && costs[x*r+d] < bc) begin
               bc   = costs[x*r+d];
               best = d;
            end
         end
         exp_r.push_back(16'(best << FRAC));
      end
   endtask

   task automatic gen_costs(input int w, input int r, input int mode);
      int c;
      costs.delete();
      for (int x = 0; x < w; x++)
         for (int d = 0; d < r; d++) begin
            if (mode == 1) c = (d > 5) ? d - 5 : 5 - d;
            else if ($urandom_range(0, 7) == 0) c = int'($urandom_range(0, 65535));
            else c = int'($urandom_range(0, 15));
            costs.push_back(c);
         end
   endtask

   task automatic push_cost(input int c, input bit gaps, input bit ctog);
      bit done = 1'b0;
      int guard = 0;
      while (!done) begin
         cost_in    = 16'(c);
         cost_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         clken      = ctog ? ($urandom_range(0, 3) != 0) : 1'b1;
         done       = cost_valid && cost_ready && clken;
         @(posedge clk);
         #1;
         guard++;
         if (!done && guard > 300) begin
            check("accept_timeout", 32'd0, 32'd1);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1, "FAIL accept_timeout");
         end
      end
   endtask

   task automatic drive_row(input int w, input int r, input int n, input bit gaps, input bit ctog);
      width = 11'(w);
      range = 9'(r);
      for (int i = 0; i < n; i++) begin
         push_cost(costs[i], gaps, ctog);
         if (i == 0) begin
            width = 11'($urandom_range(1, 2047));
            range = 9'($urandom_range(1, 511));
         end
      end
      cost_valid = 1'b0;
      clken      = 1'b1;
   endtask

   task automatic idle(input int n);
      cost_valid = 1'b0;
      clken      = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_vL"}, {31'd0, valid_final_L}, 32'd0);
      check({tag, "_vR"}, {31'd0, valid_final_R}, 32'd0);
      check({tag, "_dL"}, {16'd0, disp_L}, 32'd0);
      check({tag, "_dR"}, {16'd0, disp_R}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "FAIL watchdog");
   end

   initial begin
      int w, r, flush_exp;
      #12;
      check_outputs_zero("reset");
      check("reset_ready", {31'd0, cost_ready}, 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle(2);

      // Basic 4x2 row
      costs = '{5, 3, 7, 2, 4, 4, 9, 1};
      model_row(4, 2);
      flush_cycles = 0;
      drive_row(4, 2, 8, 1'b0, 1'b0);
      idle(10);
      check("basic_flush_cycles", 32'(flush_cycles), 32'd1);
      check("basic_L_drained", 32'(exp_l.size()), 32'd0);
      check("basic_R_drained", 32'(exp_r.size()), 32'd0);

      // range=1: no flush, left and right coincide
      gen_costs(3, 1, 0);
      model_row(3, 1);
      flush_cycles = 0;
      chk_coincide = 1'b1;
      drive_row(3, 1, 3, 1'b0, 1'b0);
      idle(5);
      chk_coincide = 1'b0;
      check("r1_flush_cycles", 32'(flush_cycles), 32'd0);

      // Full-range row with cost |d-5|
      gen_costs(MAXD, MAXD, 1);
      model_row(MAXD, MAXD);
      flush_cycles = 0;
      drive_row(MAXD, MAXD, MAXD*MAXD, 1'b0, 1'b0);
      idle(MAXD + 8);
      check("maxd_flush_cycles", 32'(flush_cycles), 32'(MAXD - 1));

      // Back-to-back random rows with valid gaps and clken toggling
      flush_cycles = 0;
      flush_exp    = 0;
      for (int k = 0; k < 7; k++) begin
         if (k == 6) begin
            r = 20;
            w = 80;
         end else begin
            r = $urandom_range(1, (k % 2) ? MAXD : 8);
            w = $urandom_range(r, 50);
         end
         gen_costs(w, r, 0);
         model_row(w, r);
         flush_exp += r - 1;
         drive_row(w, r, w*r, 1'b1, 1'b1);
      end
      idle(MAXD + 8);
      check("rand_flush_cycles", 32'(flush_cycles), 32'(flush_exp));
      check("rand_L_drained", 32'(exp_l.size()), 32'd0);
      check("rand_R_drained", 32'(exp_r.size()), 32'd0);

      // Reset mid-row, then a full row
      ignore_out = 1'b1;
      gen_costs(10, 4, 0);
      drive_row(10, 4, 15, 1'b0, 1'b0);
      rst = 1'b0;
      #3;
      check_outputs_zero("midrst");
      @(posedge clk);
      #1;
      rst = 1'b1;
      exp_l.delete();
      exp_r.delete();
      #3;
      check_outputs_zero("postrst");
      check("postrst_ready", {31'd0, cost_ready}, 32'd1);
      ignore_out = 1'b0;
      @(posedge clk);
      #1;
      gen_costs(12, 5, 0);
      model_row(12, 5);
      flush_cycles = 0;
      drive_row(12, 5, 60, 1'b1, 1'b0);
      idle(20);
      check("after_rst_flush_cycles", 32'(flush_cycles), 32'd4);

      check("final_L_drained", 32'(exp_l.size()), 32'd0);
      check("final_R_drained", 32'(exp_r.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
